// File: rtl/mac_share_arb.sv
// mac_share_arb: round-robin arbiter in front of one shared combinational
// multiply-accumulate unit (R = A*B + C). Stage 1 holds the granted job's
// operands and drives the mac; stage 2 captures the mac result and presents
// it, tagged with the requester index, on a single response port.
//
// Handshake semantics (both request and response side): a transfer happens on
// a rising clock edge where valid and ready are both high. A requester keeps
// valid and its operands steady until it sees ready. req_ready never depends
// on anything but the arbiter state, pipeline occupancy, rsp_ready and
// req_valid, and at most one req_ready bit is high in any cycle. Once
// rsp_valid rises, rsp_r/rsp_id hold until the cycle rsp_ready is high.
module mac_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic [16*NREQ-1:0]   req_c,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_r,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          mac_a,
    output logic [15:0]          mac_b,
    output logic [15:0]          mac_c,
    input  logic [31:0]          mac_r
);

    localparam int               PADW    = 2 ** IDW;
    localparam logic [IDW:0]     NREQ_X  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]   LAST_ID = IDW'(NREQ - 1);

    // Round-robin pointer: the index scanned first in the next grant search.
    logic [IDW-1:0]   rr_ptr;

    // Stage 1: operands of the job currently on the mac inputs.
    logic             s1_valid;
    logic [15:0]      s1_a;
    logic [15:0]      s1_b;
    logic [15:0]      s1_c;
    logic [IDW-1:0]   s1_id;

    // Stage 2: captured result waiting for the consumer.
    logic             s2_valid;

    // Arbitration and flow-control terms.
    logic [PADW-1:0]  valid_pad;
    logic [IDW:0]     scan_idx;
    logic             grant_valid;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   next_ptr;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic [15:0]      sel_c;
    logic             s2_free;
    logic             s1_adv;
    logic             s1_load_ok;
    logic             accept;

    // Widen req_valid to the full ID range so it can be indexed by an ID.
    always_comb begin
        valid_pad              = '0;
        valid_pad[NREQ-1:0]    = req_valid;
    end

    // Grant search: first asserted request at or after rr_ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_idx >= NREQ_X) begin
                scan_idx = scan_idx - NREQ_X;
            end
            if (!grant_valid && valid_pad[scan_idx[IDW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
                sel_c = req_c[16*i +: 16];
            end
        end
    end

    // Pipeline flow control: s2 drains when taken, s1 moves when s2 can take it.
    always_comb begin
        s2_free    = !s2_valid || rsp_ready;
        s1_adv     = s1_valid && s2_free;
        s1_load_ok = !s1_valid || s1_adv;
        accept     = !rst && grant_valid && s1_load_ok;
        next_ptr   = (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);
    end

    // One-hot ready toward the granted requester; nothing is offered in reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (grant_idx == IDW'(i));
        end
    end

    // Pointer moves past the winner only on an actual accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= next_ptr;
        end
    end

    // Stage 1: load on accept, empty when the job moves on with no replacement.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_id    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= sel_a;
            s1_b     <= sel_b;
            s1_c     <= sel_c;
            s1_id    <= grant_idx;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: capture the mac result as the job leaves stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            rsp_r    <= '0;
            rsp_id   <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            rsp_r    <= mac_r;
            rsp_id   <= s1_id;
        end else if (s2_valid && rsp_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // The mac sees stage-1 operands; they hold their last value when s1 empties.
    always_comb begin
        mac_a     = s1_a;
        mac_b     = s1_b;
        mac_c     = s1_c;
        rsp_valid = s2_valid;
    end

endmodule

// File: tb/tb_mac_share_arb.sv
// Bench for mac_share_arb: a job-level reference model (queue of outstanding
// jobs, round-robin pointer, occupancy limit of two) compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mac_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 3;
    localparam int EW   = 64 + IDW;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [16*NREQ-1:0]   req_c;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_r;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          mac_a;
    logic [15:0]          mac_b;
    logic [15:0]          mac_c;
    logic [31:0]          mac_r;
    logic                 approx;

    int n_checks;
    int n_errors;

    mac_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_id    (rsp_id),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_r     (mac_r)
    );

    // Stand-in mac unit; "approx" mode perturbs the LSB so pass-through is visible.
    function automatic logic [31:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic ap);
        logic [31:0] r;
        r = {16'd0, a} * {16'd0, b} + {16'd0, c};
        if (ap) r = r | 32'd1;
        return r;
    endfunction

    assign mac_r = mac_fn(mac_a, mac_b, mac_c, approx);

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Entry = {accept cycle, id, result}.
    logic [EW-1:0] exp_q[$];
    int            cyc;
    int            last_pop;
    int            m_ptr;

    initial begin
        cyc      = 0;
        last_pop = -1;
        m_ptr    = 0;
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        logic            found;
        logic            can_acc;
        logic            vis;
        logic [EW-1:0]   head;
        int              g;
        int              head_acc;
        int              vis_at;

        exp_ready = '0;
        found     = 1'b0;
        g         = 0;
        can_acc   = !rst && ((exp_q.size() < 2) || rsp_ready);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        if (found && can_acc) exp_ready[g] = 1'b1;
        check("mdl_req_ready", 32'(req_ready), 32'(exp_ready));

        vis = 1'b0;
        if (exp_q.size() > 0) begin
            head     = exp_q[0];
            head_acc = int'(head[EW-1:IDW+32]);
            vis_at   = (head_acc + 2 > last_pop + 1) ? head_acc + 2 : last_pop + 1;
            vis      = (cyc >= vis_at);
        end
        check("mdl_rsp_valid", 32'(rsp_valid), 32'(vis));
        if (vis) begin
            check("mdl_rsp_r", rsp_r, head[31:0]);
            check("mdl_rsp_id", 32'(rsp_id), 32'(head[IDW+31:32]));
        end

        if (rst) begin
            exp_q.delete();
            m_ptr    = 0;
            last_pop = -1;
        end else begin
            if (vis && rsp_ready) begin
                void'(exp_q.pop_front());
                last_pop = cyc;
            end
            if (found && can_acc) begin
                exp_q.push_back({32'(cyc), IDW'(g),
                                 mac_fn(req_a[16*g +: 16], req_b[16*g +: 16],
                                        req_c[16*g +: 16], approx)});
                m_ptr = (g + 1) % NREQ;
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_c[16*i +: 16] = c;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        next();
        next();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) next();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] sampled;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        rsp_ready = 1'b1;
        approx    = 1'b0;

        // Reset values.
        next();
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_r", rsp_r, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_mac_a", 32'(mac_a), 32'd0);
        check("rst_mac_b", 32'(mac_b), 32'd0);
        check("rst_mac_c", 32'(mac_c), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        next();
        rst = 1'b0;

        // Single job from requester 2: 3*5+7 = 22, visible two cycles later.
        set_op(2, 16'd3, 16'd5, 16'd7);
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'b0100);
        next();
        req_valid = '0;
        next();
        @(negedge clk);
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_r", rsp_r, 32'd22);
        check("single_id", 32'(rsp_id), 32'd2);
        next();
        @(negedge clk);
        check("single_done", 32'(rsp_valid), 32'd0);

        // Round robin with all requesters held: one accept and one response per cycle.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 1), 16'd10, 16'd0);
        req_valid = 4'b1111;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            if (t < 5) check("rr_ready", 32'(req_ready), 32'(1 << (t % 4)));
            if (t >= 2) begin
                check("rr_valid", 32'(rsp_valid), 32'd1);
                check("rr_id", 32'(rsp_id), 32'((t - 2) % 4));
                check("rr_r", rsp_r, 32'(10 * ((t - 2) % 4 + 1)));
            end
            next();
            if (t == 4) req_valid = '0;
        end
        @(negedge clk);
        check("rr_done", 32'(rsp_valid), 32'd0);

        // Backpressure: two jobs fill the pipeline, consumer stalls five cycles.
        do_reset();
        rsp_ready = 1'b0;
        set_op(0, 16'd2, 16'd3, 16'd4);
        set_op(1, 16'd5, 16'd6, 16'd1);
        set_op(3, 16'd100, 16'd200, 16'd5);
        req_valid = 4'b0011;
        @(negedge clk);
        check("bp_ready0", 32'(req_ready), 32'b0001);
        next();
        req_valid = 4'b0010;
        @(negedge clk);
        check("bp_ready1", 32'(req_ready), 32'b0010);
        next();
        req_valid = 4'b1000;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_r", rsp_r, 32'd10);
            check("bp_hold_id", 32'(rsp_id), 32'd0);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            next();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_r0", rsp_r, 32'd10);
        check("bp_rel_ready", 32'(req_ready), 32'b1000);
        next();
        req_valid = '0;
        @(negedge clk);
        check("bp_rel_r1", rsp_r, 32'd31);
        check("bp_rel_id1", 32'(rsp_id), 32'd1);
        next();
        @(negedge clk);
        check("bp_rel_r3", rsp_r, 32'd20005);
        check("bp_rel_id3", 32'(rsp_id), 32'd3);
        next();
        @(negedge clk);
        check("bp_done", 32'(rsp_valid), 32'd0);

        // Pointer wrap: drive pointer to 3, then only requester 1, then 0 and 2.
        do_reset();
        set_op(2, 16'd1, 16'd1, 16'd1);
        req_valid = 4'b0100;
        @(negedge clk);
        check("wrap_ready2", 32'(req_ready), 32'b0100);
        next();
        set_op(1, 16'd2, 16'd2, 16'd2);
        req_valid = 4'b0010;
        @(negedge clk);
        check("wrap_ready1", 32'(req_ready), 32'b0010);
        next();
        set_op(0, 16'd4, 16'd4, 16'd4);
        set_op(2, 16'd7, 16'd7, 16'd7);
        req_valid = 4'b0101;
        @(negedge clk);
        check("wrap_ready2b", 32'(req_ready), 32'b0100);
        next();
        req_valid = 4'b0001;
        @(negedge clk);
        check("wrap_ready0", 32'(req_ready), 32'b0001);
        next();
        req_valid = '0;
        drain(4);

        // Reset with both stages full: everything discarded, pointer back to 0.
        do_reset();
        rsp_ready = 1'b0;
        set_op(0, 16'd9, 16'd9, 16'd9);
        set_op(1, 16'd8, 16'd8, 16'd8);
        req_valid = 4'b0011;
        @(negedge clk);
        check("rmf_ready0", 32'(req_ready), 32'b0001);
        next();
        req_valid = 4'b0010;
        @(negedge clk);
        check("rmf_ready1", 32'(req_ready), 32'b0010);
        next();
        req_valid = 4'b1111;
        @(negedge clk);
        check("rmf_full_valid", 32'(rsp_valid), 32'd1);
        check("rmf_full_ready", 32'(req_ready), 32'd0);
        next();
        rst = 1'b1;
        @(negedge clk);
        check("rmf_rst_ready", 32'(req_ready), 32'd0);
        next();
        @(negedge clk);
        check("rmf_post_valid", 32'(rsp_valid), 32'd0);
        check("rmf_post_ready", 32'(req_ready), 32'd0);
        check("rmf_post_mac_a", 32'(mac_a), 32'd0);
        next();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("rmf_no_stale", 32'(rsp_valid), 32'd0);
            next();
        end
        set_op(3, 16'd3, 16'd3, 16'd3);
        req_valid = 4'b1010;
        @(negedge clk);
        check("rmf_ptr0", 32'(req_ready), 32'b0010);
        next();
        req_valid = 4'b1000;
        @(negedge clk);
        check("rmf_ptr_next", 32'(req_ready), 32'b1000);
        next();
        req_valid = '0;
        drain(4);

        // Perturbed mac: response must carry mac_r bit-for-bit.
        approx = 1'b1;
        set_op(3, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b1000;
        @(negedge clk);
        check("mac_ready", 32'(req_ready), 32'b1000);
        next();
        req_valid = '0;
        @(negedge clk);
        sampled = mac_r;
        check("mac_a_drive", 32'(mac_a), 32'h0000FFFF);
        next();
        @(negedge clk);
        check("mac_valid", 32'(rsp_valid), 32'd1);
        check("mac_r_pass", rsp_r, sampled);
        check("mac_r_lit", rsp_r, 32'hFFFF0001);
        check("mac_id", 32'(rsp_id), 32'd3);
        next();
        drain(2);
        approx = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
